// File: rtl/ofm_writer.sv
// ---------------------------------------------------------------------------
// ofm_writer
//   Streams a layer's output feature map (OFM) from the compute pipeline into
//   DDR. Each 64-bit beat becomes a single-beat, 8-byte AXI write. Beat k
//   goes to base_addr + 8*k, and the address wraps modulo 2^ADDR_W. Incoming
//   beats are buffered in a small FIFO. The address channel runs ahead of
//   the data channel and does not wait for data.
//
// Parameters
//   FIFO_DEPTH : beats buffered between s_* and the W channel
//                (power of two, >= 2)
//   ADDR_W     : AXI address width
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : one-cycle pulse, accepted only when idle
//   base_addr         : byte address of the first beat (sampled on start)
//   num_beats         : number of beats to write (sampled on start)
//   busy              : high from the accepted start until done
//   done              : one-cycle completion pulse
//   s_data/s_valid    : OFM beat stream from the compute pipeline
//   s_ready           : block accepts s_data this cycle
//   m_axi_ofm_aw*     : AXI write-address channel (single beat)
//   m_axi_ofm_w*      : AXI write-data channel (single beat)
// ---------------------------------------------------------------------------
module ofm_writer #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       num_beats,
    output logic              busy,
    output logic              done,
    input  logic [63:0]       s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] m_axi_ofm_awaddr,
    output logic              m_axi_ofm_awvalid,
    input  logic              m_axi_ofm_awready,
    output logic [63:0]       m_axi_ofm_wdata,
    output logic              m_axi_ofm_wvalid,
    input  logic              m_axi_ofm_wready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, next_state;
    logic [15:0]      nb;                   // num_beats latched for this job
    logic [15:0]      in_cnt, aw_cnt, w_cnt;
    logic [63:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, empty, push, pop, aw_hs, start_ok;
    logic             aw_last, w_last;

    assign start_ok = (state == IDLE) && start;
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);

    // The full check ignores a pop in the same cycle. This keeps s_ready
    // free of any combinational path from wready.
    assign s_ready = (state == RUN) && !full && (in_cnt < nb);
    assign push    = s_valid && s_ready;

    assign m_axi_ofm_wvalid  = (state == RUN) && !empty;
    assign pop               = m_axi_ofm_wvalid && m_axi_ofm_wready;
    // Drive wdata to zero when nothing is valid. This keeps it zero in reset
    // even though the storage array itself is never cleared.
    assign m_axi_ofm_wdata   = m_axi_ofm_wvalid ? mem[rd_ptr] : '0;

    assign m_axi_ofm_awvalid = (state == RUN) && (aw_cnt < nb);
    assign aw_hs             = m_axi_ofm_awvalid && m_axi_ofm_awready;

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

    // Look ahead by the handshakes that complete in this cycle. This raises
    // done in the cycle right after the final AW/W handshake.
    assign aw_last = ((aw_cnt + 16'(aw_hs)) == nb);
    assign w_last  = ((w_cnt + 16'(pop)) == nb);

    // NOTE: combinational blocks assign every output a default first, so no
    // path through the case can leave a value held and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = (num_beats == '0) ? DONE : RUN;
            RUN:  if (aw_last && w_last) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Job counters and the write-address register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nb               <= '0;
            in_cnt           <= '0;
            aw_cnt           <= '0;
            w_cnt            <= '0;
            m_axi_ofm_awaddr <= '0;
        end else if (start_ok) begin
            nb               <= num_beats;
            in_cnt           <= '0;
            aw_cnt           <= '0;
            w_cnt            <= '0;
            m_axi_ofm_awaddr <= base_addr;
        end else begin
            if (push) in_cnt <= in_cnt + 16'd1;
            if (pop)  w_cnt  <= w_cnt + 16'd1;
            if (aw_hs) begin
                aw_cnt           <= aw_cnt + 16'd1;
                m_axi_ofm_awaddr <= m_axi_ofm_awaddr + ADDR_W'(8);
            end
        end
    end

    // FIFO control. Pointers wrap naturally because the depth is a power
    // of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset. Emptiness is tracked by the
    // pointers and the count, so stale contents are never presented.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

endmodule

// File: tb/tb_ofm_writer.sv
// ---------------------------------------------------------------------------
// tb_ofm_writer
//   Scoreboard bench for ofm_writer. Stimulus pushes the expected AW
//   addresses and W data into queues. A monitor on the falling edge pops
//   and compares them at each AXI handshake, and checks that stalled
//   channels hold their values.
// ---------------------------------------------------------------------------
module tb_ofm_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] num_beats = '0;
    logic        busy, done;
    logic [63:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [63:0] wdata;
    logic        wvalid;
    logic        wready = 1'b0;

    ofm_writer #(.FIFO_DEPTH(8), .ADDR_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .base_addr         (base_addr),
        .num_beats         (num_beats),
        .busy              (busy),
        .done              (done),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .m_axi_ofm_awaddr  (awaddr),
        .m_axi_ofm_awvalid (awvalid),
        .m_axi_ofm_awready (awready),
        .m_axi_ofm_wdata   (wdata),
        .m_axi_ofm_wvalid  (wvalid),
        .m_axi_ofm_wready  (wready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] aw_exp[$];
    logic [63:0] w_exp[$];

    int aw_hs_n = 0, w_hs_n = 0, done_n = 0;
    int cyc = 0, last_hs_cyc = 0, done_cyc = 0;
    int acc = 0;
    bit abort = 1'b0;
    bit aw_rand = 1'b0, w_rand = 1'b0;
    logic aw_fix = 1'b1, w_fix = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: condition not reached (t=%0t)", name, $time);
    endtask

    always @(posedge clk) cyc++;

    // Slave ready generation: either a fixed level or a 50% random draw each cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            awready = aw_rand ? 1'($urandom_range(0, 1)) : aw_fix;
            wready  = w_rand  ? 1'($urandom_range(0, 1)) : w_fix;
        end
    end

    // Monitor and scoreboard.
    logic        prev_aw_stall = 1'b0, prev_w_stall = 1'b0, prev_done = 1'b0;
    logic [31:0] prev_awaddr = '0;
    logic [63:0] prev_wdata = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_aw_stall = 1'b0;
            prev_w_stall  = 1'b0;
            prev_done     = 1'b0;
        end else begin
            if (prev_aw_stall) begin
                check("aw_hold_valid", 64'(awvalid), 64'd1);
                check("aw_hold_addr", 64'(awaddr), 64'(prev_awaddr));
            end
            if (prev_w_stall) begin
                check("w_hold_valid", 64'(wvalid), 64'd1);
                check("w_hold_data", wdata, prev_wdata);
            end
            if (awvalid && awready) begin
                aw_hs_n++;
                last_hs_cyc = cyc;
                if (aw_exp.size() == 0) fail("aw_unexpected_handshake");
                else check("awaddr", 64'(awaddr), 64'(aw_exp.pop_front()));
            end
            if (wvalid && wready) begin
                w_hs_n++;
                last_hs_cyc = cyc;
                if (w_exp.size() == 0) fail("w_unexpected_handshake");
                else check("wdata", wdata, w_exp.pop_front());
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
                check("done_with_busy", 64'(busy), 64'd1);
                check("done_single_cycle", 64'(prev_done), 64'd0);
            end
            prev_aw_stall = awvalid && !awready;
            prev_w_stall  = wvalid && !wready;
            prev_awaddr   = awaddr;
            prev_wdata    = wdata;
            prev_done     = done;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    64'(busy),    64'd0);
        check({tag, "_done"},    64'(done),    64'd0);
        check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        check({tag, "_awvalid"}, 64'(awvalid), 64'd0);
        check({tag, "_wvalid"},  64'(wvalid),  64'd0);
        check({tag, "_awaddr"},  64'(awaddr),  64'd0);
        check({tag, "_wdata"},   wdata,        64'd0);
    endtask

    task automatic start_job(input logic [31:0] b, input logic [15:0] n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        num_beats = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_addrs(input logic [31:0] b, input int n);
        for (int k = 0; k < n; k++) aw_exp.push_back(b + 32'(8 * k));
    endtask

    // Offers n beats on s_*. Each accepted beat goes into the W scoreboard.
    task automatic feed(input int n, input logic [7:0] tag, input bit rnd);
        int budget;
        budget = 20000;
        acc = 0;
        while (acc < n && !abort && budget > 0) begin
            s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = {8'hA5, tag, 16'h5A5A, 16'h0000, 16'(acc)};
            @(negedge clk);
            if (s_valid && s_ready) begin
                w_exp.push_back(s_data);
                acc++;
            end
            @(posedge clk);
            #1;
            budget--;
        end
        if (acc < n && !abort) fail("feed_timeout");
        if (!abort && n > 0) begin
            // A beat offered after the job's quota must be refused.
            s_valid = 1'b1;
            s_data  = 64'hDEAD_BEEF_DEAD_BEEF;
            @(negedge clk);
            check("s_ready_after_quota", 64'(s_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int c;
        c = 0;
        while (done_n == d0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (done_n == d0) fail("done_timeout");
        @(negedge clk);
        check("idle_after_done_busy", 64'(busy), 64'd0);
    endtask

    task automatic post_job(input string tag, input int n, input int aw0, input int w0, input int d0);
        check({tag, "_aw_count"},   64'(aw_hs_n - aw0), 64'(n));
        check({tag, "_w_count"},    64'(w_hs_n - w0),   64'(n));
        check({tag, "_done_count"}, 64'(done_n - d0),   64'd1);
        check({tag, "_aw_left"},    64'(aw_exp.size()), 64'd0);
        check({tag, "_w_left"},     64'(w_exp.size()),  64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int aw0, w0, d0, c;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Four beats with all handshakes free-running.
        aw0 = aw_hs_n; w0 = w_hs_n; d0 = done_n;
        aw_exp.push_back(32'h1000_0000);
        aw_exp.push_back(32'h1000_0008);
        aw_exp.push_back(32'h1000_0010);
        aw_exp.push_back(32'h1000_0018);
        start_job(32'h1000_0000, 16'd4);
        feed(4, 8'h01, 1'b0);
        wait_done(d0, 200);
        check("basic_done_latency", 64'(done_cyc), 64'(last_hs_cyc + 1));
        post_job("basic", 4, aw0, w0, d0);

        // A zero-beat job finishes immediately and generates no AXI traffic.
        aw0 = aw_hs_n; w0 = w_hs_n; d0 = done_n;
        start_job(32'h2222_0000, 16'd0);
        @(negedge clk);
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd1);
        check("zero_awvalid", 64'(awvalid), 64'd0);
        check("zero_wvalid", 64'(wvalid), 64'd0);
        @(negedge clk);
        check("zero_done_clear", 64'(done), 64'd0);
        check("zero_busy_clear", 64'(busy), 64'd0);
        post_job("zero", 0, aw0, w0, d0);

        // W stalled for 20 cycles: the FIFO fills with 8 beats, then drains.
        aw0 = aw_hs_n; w0 = w_hs_n; d0 = done_n;
        w_fix = 1'b0;
        push_addrs(32'h2000_0000, 16);
        start_job(32'h2000_0000, 16'd16);
        fork
            feed(16, 8'h02, 1'b0);
            begin
                repeat (20) @(negedge clk);
                check("stall_accepted", 64'(acc), 64'd8);
                check("stall_s_ready", 64'(s_ready), 64'd0);
                check("stall_wvalid", 64'(wvalid), 64'd1);
                w_fix = 1'b1;
            end
        join
        wait_done(d0, 300);
        post_job("stall", 16, aw0, w0, d0);

        // Random 50% back-pressure on both AXI channels, 100 beats.
        aw0 = aw_hs_n; w0 = w_hs_n; d0 = done_n;
        aw_rand = 1'b1;
        w_rand  = 1'b1;
        push_addrs(32'h3000_0100, 100);
        start_job(32'h3000_0100, 16'd100);
        feed(100, 8'h03, 1'b1);
        wait_done(d0, 5000);
        post_job("random", 100, aw0, w0, d0);
        aw_rand = 1'b0;
        w_rand  = 1'b0;

        // The address wraps past the top of the 32-bit space.
        aw0 = aw_hs_n; w0 = w_hs_n; d0 = done_n;
        aw_exp.push_back(32'hFFFF_FFF8);
        aw_exp.push_back(32'h0000_0000);
        start_job(32'hFFFF_FFF8, 16'd2);
        feed(2, 8'h04, 1'b0);
        wait_done(d0, 200);
        post_job("wrap", 2, aw0, w0, d0);

        // Reset mid-job, then run a fresh two-beat job.
        w0 = w_hs_n;
        push_addrs(32'h4000_0000, 10);
        start_job(32'h4000_0000, 16'd10);
        fork
            feed(10, 8'h05, 1'b0);
            begin
                c = 0;
                while (w_hs_n - w0 < 3 && c < 200) begin
                    @(negedge clk);
                    c++;
                end
                if (w_hs_n - w0 < 3) fail("abort_wait_timeout");
                abort = 1'b1;
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midreset");
                repeat (3) @(negedge clk);
                check_reset_outputs("midreset_hold");
                aw_exp.delete();
                w_exp.delete();
            end
        join
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        abort = 1'b0;
        aw0 = aw_hs_n; w0 = w_hs_n; d0 = done_n;
        push_addrs(32'h5000_0000, 2);
        start_job(32'h5000_0000, 16'd2);
        feed(2, 8'h06, 1'b0);
        wait_done(d0, 200);
        post_job("after_reset", 2, aw0, w0, d0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ofm_writer.md
OFM_WRITER -- requirements
Module: ofm_writer

Interface
REQ-001 Parameters: FIFO_DEPTH, default 8, number of 64-bit beats buffered (power of two, >=2); ADDR_W, default 32, AXI address width.
REQ-002 clk  input  1  sole clock; all logic rising-edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle pulse; begins a layer write-back.
REQ-005 base_addr  input  ADDR_W  DDR byte address of first OFM beat; sampled on accepted start.
REQ-006 num_beats  input  16  number of 64-bit beats to write; sampled on accepted start.
REQ-007 busy  output  1  high from accepted start until done.
REQ-008 done  output  1  one-cycle pulse when all beats are written.
REQ-009 s_data  input  64  OFM beat from the compute pipeline.
REQ-010 s_valid  input  1  s_data valid.
REQ-011 s_ready  output  1  block accepts s_data this cycle.
REQ-012 m_axi_ofm_awaddr  output  ADDR_W  write address.
REQ-013 m_axi_ofm_awvalid  output  1  address valid.
REQ-014 m_axi_ofm_awready  input  1  slave accepts address.
REQ-015 m_axi_ofm_wdata  output  64  write data.
REQ-016 m_axi_ofm_wvalid  output  1  data valid.
REQ-017 m_axi_ofm_wready  input  1  slave accepts data.

Function
REQ-018 FSM states IDLE, RUN, DONE; start accepted only in IDLE, ignored in RUN/DONE.
REQ-019 IDLE->RUN on start with num_beats!=0; IDLE->DONE on start with num_beats==0 (no AXI traffic); RUN->DONE when aw_cnt==num_beats and w_cnt==num_beats; DONE->IDLE unconditionally after one cycle.
REQ-020 done=1 exactly while in DONE; busy=1 in RUN and DONE.
REQ-021 Every AXI transaction is single-beat, 8 bytes; beat k address = base_addr + 8*k, modulo 2^ADDR_W (wrap permitted, no error).
REQ-022 Address channel: awvalid=1 in RUN while aw_cnt<num_beats; aw_cnt and awaddr advance only on awvalid&&awready; awaddr held stable while awvalid&&!awready.
REQ-023 Address channel is independent of data availability; AW may lead W by any amount.
REQ-024 Data path: FIFO of FIFO_DEPTH beats; s_ready = (state==RUN) && !full && (in_cnt<num_beats).
REQ-025 Push on s_valid&&s_ready; in_cnt increments per push.
REQ-026 wvalid = (state==RUN) && !empty; wdata = FIFO head; pop and w_cnt increment on wvalid&&wready; wdata held stable while wvalid&&!wready.
REQ-027 Latency: beat pushed in cycle N is presentable on wdata in cycle N+1 at earliest (empty FIFO).
REQ-028 Simultaneous push and pop: occupancy unchanged, both take effect; when full, s_ready=0 even if pop occurs that cycle.
REQ-029 Beats written in exactly the order accepted; no beat dropped or duplicated.
REQ-030 Counters 16-bit; in_cnt, aw_cnt, w_cnt cleared on each accepted start.
REQ-031 Beats offered after in_cnt reaches num_beats are not accepted (s_ready=0).

Reset
REQ-032 rst_n low asynchronously forces IDLE, empties FIFO, clears all counters; outputs: busy=0, done=0, s_ready=0, awvalid=0, wvalid=0, awaddr=0, wdata=0.
REQ-033 Reset asserted mid-transfer abandons outstanding beats; after release, block accepts a new start normally.

Verification
REQ-034 start, base_addr=0x1000_0000, num_beats=4, s_valid and awready/wready always 1 -> addresses 0x1000_0000,08,10,18 in order, data matches inputs, done one cycle after last handshake.
REQ-035 num_beats=0 start -> done=1 on next cycle, no awvalid/wvalid, busy high for one cycle.
REQ-036 wready=0 for 20 cycles, num_beats=16, s_valid=1 -> s_ready drops after 8 beats accepted; wdata/wvalid stable; resumes in order when wready=1.
REQ-037 awready random 50%, wready random 50%, num_beats=100 -> 100 AW and 100 W handshakes, scoreboard ordering correct, single done pulse.
REQ-038 base_addr=0xFFFF_FFF8, num_beats=2 -> addresses 0xFFFF_FFF8 then 0x0000_0000.
REQ-039 rst_n low after 3 of 10 beats, then new start num_beats=2 -> all outputs at reset values during reset, second job completes with exactly 2 beats.
